// File: rtl/usb_reg_fe_sync.sv
// USB register front-end: double-registers the SAM3U bus, issues single-cycle register
// strokes and returns read data after pRD_LATENCY. Optional stream burst counter: USB_FE_STREAM_EN.
module usb_reg_fe_sync #(
    parameter int unsigned pADDR_WIDTH   = 21,
    parameter int unsigned pBYTECNT_SIZE = 7,
    parameter int unsigned pRD_LATENCY   = 2,
    parameter int unsigned pISOUT_HOLD   = 3,
    parameter int unsigned pSTREAM_ADDR  = 0
) (
    input  logic                                 usb_clk,
    input  logic                                 rst,
    input  logic [7:0]                           usb_din,
    output logic [7:0]                           usb_dout,
    output logic                                 usb_isout,
    input  logic [pADDR_WIDTH-1:0]               usb_addr,
    input  logic                                 usb_rdn,
    input  logic                                 usb_wrn,
    input  logic                                 usb_cen,
    input  logic                                 usb_alen,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    output logic [7:0]                           reg_datao,
    input  logic [7:0]                           reg_datai,
    output logic                                 reg_read,
    output logic                                 reg_write,
    output logic                                 reg_addrvalid
);

    localparam int unsigned REG_AW = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] RD_LAT   = CNT_W'(pRD_LATENCY);
    localparam logic [CNT_W-1:0] ISO_HOLD = CNT_W'(pISOUT_HOLD);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_HOLD, ISO_TAIL} state_t;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic [pADDR_WIDTH-1:0]   addr_s1, addr_s2;
    logic [7:0]               din_s1, din_s2;
    logic                     rdn_s1, rdn_s2, wrn_s1, wrn_s2, cen_s1, cen_s2;
    logic                     rd_q3, wr_q3;
    logic                     rd_q1, rd_q2, wr_q2;
    logic                     rd_start, wr_start, rd_accept, wr_accept, busy_nxt;
    logic [REG_AW-1:0]        addr_field;
    logic                     unused_alen;

    assign unused_alen = usb_alen;

    assign rd_q1 = ~cen_s1 & ~rdn_s1;
    assign rd_q2 = ~cen_s2 & ~rdn_s2;
    assign wr_q2 = ~cen_s2 & ~wrn_s2;

    assign rd_start  = rd_q2 & ~rd_q3;
    assign wr_start  = wr_q2 & ~wr_q3;
    // A read may restart during the isout tail; writes are only taken when fully idle.
    assign rd_accept = rd_start & ((state == IDLE) | (state == ISO_TAIL));
    assign wr_accept = wr_start & ~rd_start & (state == IDLE);
    assign busy_nxt  = rd_accept | (state == RD_WAIT) | (state == RD_HOLD)
                     | ((state == ISO_TAIL) & (cnt != CNT_W'(1)));

    assign addr_field = addr_s2[pADDR_WIDTH-1:pBYTECNT_SIZE];

`ifdef USB_FE_STREAM_EN
    logic [pBYTECNT_SIZE-1:0] stream_cnt;
`endif

    always_ff @(posedge usb_clk) begin
        if (rst) begin
            addr_s1       <= '0;
            addr_s2       <= '0;
            din_s1        <= '0;
            din_s2        <= '0;
            rdn_s1        <= 1'b1;
            rdn_s2        <= 1'b1;
            wrn_s1        <= 1'b1;
            wrn_s2        <= 1'b1;
            cen_s1        <= 1'b1;
            cen_s2        <= 1'b1;
            rd_q3         <= 1'b0;
            wr_q3         <= 1'b0;
            state         <= IDLE;
            cnt           <= '0;
            usb_dout      <= '0;
            usb_isout     <= 1'b0;
            reg_read      <= 1'b0;
            reg_write     <= 1'b0;
            reg_addrvalid <= 1'b0;
            reg_address   <= '0;
            reg_bytecnt   <= '0;
            reg_datao     <= '0;
`ifdef USB_FE_STREAM_EN
            stream_cnt    <= '0;
`endif
        end else begin
            addr_s1 <= usb_addr;
            addr_s2 <= addr_s1;
            din_s1  <= usb_din;
            din_s2  <= din_s1;
            rdn_s1  <= usb_rdn;
            rdn_s2  <= rdn_s1;
            wrn_s1  <= usb_wrn;
            wrn_s2  <= wrn_s1;
            cen_s1  <= usb_cen;
            cen_s2  <= cen_s1;
            rd_q3   <= rd_q2;
            wr_q3   <= wr_q2;

            reg_read      <= rd_accept;
            reg_write     <= wr_accept;
            usb_isout     <= rd_q1 | busy_nxt;
            reg_addrvalid <= busy_nxt | wr_accept;

            // Access select is captured once per accepted access and held until the next.
            if (rd_accept | wr_accept) begin
                reg_address <= addr_field;
                reg_datao   <= din_s2;
`ifdef USB_FE_STREAM_EN
                if (addr_field == REG_AW'(pSTREAM_ADDR)) begin
                    reg_bytecnt <= stream_cnt;
                    stream_cnt  <= stream_cnt + pBYTECNT_SIZE'(1);
                end else begin
                    reg_bytecnt <= addr_s2[pBYTECNT_SIZE-1:0];
                    stream_cnt  <= '0;
                end
`else
                reg_bytecnt <= addr_s2[pBYTECNT_SIZE-1:0];
`endif
            end

            case (state)
                IDLE: begin
                    if (rd_accept) begin
                        state <= RD_WAIT;
                        cnt   <= RD_LAT;
                    end
                end
                RD_WAIT: begin
                    if (cnt == '0) begin
                        usb_dout <= reg_datai;
                        if (rd_q2) begin
                            state <= RD_HOLD;
                        end else begin
                            state <= ISO_TAIL;
                            cnt   <= ISO_HOLD;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RD_HOLD: begin
                    if (!rd_q2) begin
                        state <= ISO_TAIL;
                        cnt   <= ISO_HOLD;
                    end
                end
                ISO_TAIL: begin
                    if (rd_accept) begin
                        state <= RD_WAIT;
                        cnt   <= RD_LAT;
                    end else if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_reg_fe_sync.sv
// Bench for usb_reg_fe_sync: directed literal checks plus randomized host traffic
// compared every cycle against a timestamp-based transaction model.
module tb_usb_reg_fe_sync;

    localparam int unsigned AW = 21;
    localparam int unsigned BC = 7;
    localparam int unsigned L  = 2;
    localparam int unsigned H  = 3;
    localparam int unsigned SA = 0;

    logic              usb_clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        usb_din = '0;
    logic [7:0]        usb_dout;
    logic              usb_isout;
    logic [AW-1:0]     usb_addr = '0;
    logic              usb_rdn = 1'b1;
    logic              usb_wrn = 1'b1;
    logic              usb_cen = 1'b1;
    logic              usb_alen = 1'b0;
    logic [AW-BC-1:0]  reg_address;
    logic [BC-1:0]     reg_bytecnt;
    logic [7:0]        reg_datao;
    logic [7:0]        reg_datai = '0;
    logic              reg_read, reg_write, reg_addrvalid;

    usb_reg_fe_sync #(
        .pADDR_WIDTH(AW), .pBYTECNT_SIZE(BC), .pRD_LATENCY(L),
        .pISOUT_HOLD(H), .pSTREAM_ADDR(SA)
    ) dut (
        .usb_clk(usb_clk), .rst(rst), .usb_din(usb_din), .usb_dout(usb_dout),
        .usb_isout(usb_isout), .usb_addr(usb_addr), .usb_rdn(usb_rdn),
        .usb_wrn(usb_wrn), .usb_cen(usb_cen), .usb_alen(usb_alen),
        .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .reg_datao(reg_datao),
        .reg_datai(reg_datai), .reg_read(reg_read), .reg_write(reg_write),
        .reg_addrvalid(reg_addrvalid)
    );

    always #5 usb_clk = ~usb_clk;

    int n_chk = 0;
    int n_err = 0;
    bit rnd_datai = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a read accepted at edge S captures at S+L+1; it enters the isout tail at
    // the first edge E >= S+L+1 whose two-stage-delayed strobe is inactive, and is idle at E+H.
    int unsigned   edge_n = 0;
    bit            model_ok = 1'b0;
    bit            have = 1'b0, e_known = 1'b0;
    int unsigned   s_edge = 0, e_edge = 0;
    logic          p1 = 0, p2 = 0, p3 = 0, w1 = 0, w2 = 0, w3 = 0;
    logic [AW-1:0] a1 = '0, a2 = '0;
    logic [7:0]    d1 = '0, d2 = '0;
    logic [7:0]    m_dout = '0, m_datao = '0;
    logic [AW-BC-1:0] m_address = '0;
    logic [BC-1:0] m_bytecnt = '0, m_stream = '0;
    logic          m_isout = 0, m_read = 0, m_write = 0, m_valid = 0;
    bit            cr, cw, rs, ws, ar, aw;

    function automatic bit busy_at(input int unsigned j);
        return have && (!e_known || j < e_edge + H);
    endfunction

    function automatic bit can_start(input int unsigned j);
        return !have || (e_known && j >= e_edge);
    endfunction

    always @(posedge usb_clk) begin
        edge_n++;
        cr = !usb_cen && !usb_rdn;
        cw = !usb_cen && !usb_wrn;
        if (rst) begin
            have = 0; e_known = 0;
            p1 = 0; p2 = 0; p3 = 0; w1 = 0; w2 = 0; w3 = 0;
            m_dout = '0; m_datao = '0; m_address = '0; m_bytecnt = '0; m_stream = '0;
            m_isout = 0; m_read = 0; m_write = 0; m_valid = 0;
        end else begin
            rs = p2 && !p3;
            ws = w2 && !w3;
            ar = rs && can_start(edge_n - 1);
            aw = ws && !rs && !busy_at(edge_n - 1);
            if (ar) begin
                have = 1; e_known = 0; s_edge = edge_n;
            end
            if (have && !e_known && edge_n >= s_edge + L + 1 && !p2) begin
                e_known = 1; e_edge = edge_n;
            end
            if (have && edge_n == s_edge + L + 1) m_dout = reg_datai;
            m_read  = ar;
            m_write = aw;
            m_isout = p1 || busy_at(edge_n);
            m_valid = busy_at(edge_n) || aw;
            if (ar || aw) begin
                m_address = (AW-BC)'(a2 >> BC);
                m_datao   = d2;
`ifdef USB_FE_STREAM_EN
                if ((AW-BC)'(a2 >> BC) == (AW-BC)'(SA)) begin
                    m_bytecnt = m_stream;
                    m_stream  = m_stream + 1'b1;
                end else begin
                    m_bytecnt = BC'(a2);
                    m_stream  = '0;
                end
`else
                m_bytecnt = BC'(a2);
`endif
            end
            p3 = p2; p2 = p1; p1 = cr;
            w3 = w2; w2 = w1; w1 = cw;
            a2 = a1; a1 = usb_addr;
            d2 = d1; d1 = usb_din;
        end
        model_ok = 1'b1;
    end

    always @(negedge usb_clk) begin
        if (model_ok) begin
            chk("dout",      32'(usb_dout),      32'(m_dout));
            chk("isout",     32'(usb_isout),     32'(m_isout));
            chk("reg_read",  32'(reg_read),      32'(m_read));
            chk("reg_write", 32'(reg_write),     32'(m_write));
            chk("addrvalid", 32'(reg_addrvalid), 32'(m_valid));
            chk("address",   32'(reg_address),   32'(m_address));
            chk("bytecnt",   32'(reg_bytecnt),   32'(m_bytecnt));
            chk("datao",     32'(reg_datao),     32'(m_datao));
        end
    end

    task automatic tick();
        @(negedge usb_clk);
        if (rnd_datai) reg_datai = 8'($urandom);
    endtask

    task automatic release_bus();
        usb_rdn = 1'b1; usb_wrn = 1'b1; usb_cen = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((usb_isout !== 1'b0 || reg_addrvalid !== 1'b0) && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n >= 200), 32'd0);
    endtask

    task automatic do_op(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [7:0] d, input int low, input int gap);
        tick();
        usb_addr = a; usb_din = d; usb_cen = 1'b0;
        usb_rdn = ~rd; usb_wrn = ~wr;
        repeat (low) tick();
        release_bus();
        repeat (gap) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a;
        int r;

        // Reset values
        repeat (2) @(negedge usb_clk);
        chk("rst_dout", 32'(usb_dout), 32'd0);
        chk("rst_isout", 32'(usb_isout), 32'd0);
        chk("rst_valid", 32'(reg_addrvalid), 32'd0);
        chk("rst_address", 32'(reg_address), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge usb_clk);

        // Write 0xA5 to 0x000085, wrn low for 6 cycles
        @(negedge usb_clk);
        usb_addr = 21'h000085; usb_din = 8'hA5; usb_cen = 1'b0; usb_wrn = 1'b0;
        repeat (2) @(negedge usb_clk);
        chk("wr_early", 32'(reg_write), 32'd0);
        @(negedge usb_clk);
        chk("wr_pulse", 32'(reg_write), 32'd1);
        chk("wr_address", 32'(reg_address), 32'd1);
        chk("wr_bytecnt", 32'(reg_bytecnt), 32'd5);
        chk("wr_datao", 32'(reg_datao), 32'hA5);
        chk("model_wr_datao", 32'(m_datao), 32'hA5);
        repeat (3) begin
            @(negedge usb_clk);
            chk("wr_single", 32'(reg_write), 32'd0);
        end
        release_bus();
        wait_idle();

        // Read with reg_datai = 0x3C, strobe low 8 cycles
        reg_datai = 8'h3C;
        @(negedge usb_clk);
        usb_addr = 21'h000100; usb_cen = 1'b0; usb_rdn = 1'b0;
        @(negedge usb_clk);
        chk("rd_isout_pre", 32'(usb_isout), 32'd0);
        @(negedge usb_clk);
        chk("rd_isout_n1", 32'(usb_isout), 32'd1);
        @(negedge usb_clk);
        chk("rd_pulse", 32'(reg_read), 32'd1);
        chk("rd_address", 32'(reg_address), 32'd2);
        @(negedge usb_clk);
        chk("rd_single", 32'(reg_read), 32'd0);
        repeat (2) @(negedge usb_clk);
        chk("rd_dout", 32'(usb_dout), 32'h3C);
        chk("model_rd_dout", 32'(m_dout), 32'h3C);
        repeat (2) @(negedge usb_clk);
        release_bus();
        repeat (5) @(negedge usb_clk);
        chk("isout_tail_hi", 32'(usb_isout), 32'd1);
        @(negedge usb_clk);
        chk("isout_tail_lo", 32'(usb_isout), 32'd0);
        wait_idle();

        // rdn and wrn fall together: read wins
        @(negedge usb_clk);
        usb_addr = 21'h000203; usb_din = 8'h11; usb_cen = 1'b0; usb_rdn = 1'b0; usb_wrn = 1'b0;
        repeat (3) @(negedge usb_clk);
        chk("both_read", 32'(reg_read), 32'd1);
        chk("both_nowrite", 32'(reg_write), 32'd0);
        repeat (5) begin
            @(negedge usb_clk);
            chk("both_nowrite_hold", 32'(reg_write), 32'd0);
        end
        release_bus();
        wait_idle();

        // Read released during the latency wait still captures
        reg_datai = 8'h5A;
        @(negedge usb_clk);
        usb_addr = 21'h000300; usb_cen = 1'b0; usb_rdn = 1'b0;
        repeat (2) @(negedge usb_clk);
        release_bus();
        @(negedge usb_clk);
        chk("short_pulse", 32'(reg_read), 32'd1);
        repeat (3) @(negedge usb_clk);
        chk("short_dout", 32'(usb_dout), 32'h5A);
        wait_idle();
        chk("short_idle", 32'(usb_isout), 32'd0);

        // Reset while holding captured data
        reg_datai = 8'hC3;
        @(negedge usb_clk);
        usb_addr = 21'h000400; usb_cen = 1'b0; usb_rdn = 1'b0;
        repeat (7) @(negedge usb_clk);
        chk("hold_dout", 32'(usb_dout), 32'hC3);
        rst = 1'b1;
        release_bus();
        @(negedge usb_clk);
        chk("mid_rst_dout", 32'(usb_dout), 32'd0);
        chk("mid_rst_isout", 32'(usb_isout), 32'd0);
        chk("mid_rst_valid", 32'(reg_addrvalid), 32'd0);
        chk("mid_rst_address", 32'(reg_address), 32'd0);
        rst = 1'b0;
        reg_datai = 8'h99;
        do_op(1'b1, 1'b0, 21'h000480, 8'h00, 8, 0);
        wait_idle();
        chk("post_rst_dout", 32'(usb_dout), 32'h99);

`ifdef USB_FE_STREAM_EN
        // Stream register burst count
        for (int i = 0; i < 4; i++) begin
            do_op(1'b1, 1'b0, AW'((SA << BC) | $urandom_range(0, 127)), 8'h00, 8, 0);
            wait_idle();
            chk("stream_cnt", 32'(reg_bytecnt), 32'(i));
        end
        do_op(1'b1, 1'b0, AW'(((SA + 5) << BC) | 9), 8'h00, 8, 0);
        wait_idle();
        chk("stream_other", 32'(reg_bytecnt), 32'd9);
        do_op(1'b1, 1'b0, AW'((SA << BC) | 77), 8'h00, 8, 0);
        wait_idle();
        chk("stream_clear", 32'(reg_bytecnt), 32'd0);
`endif

        // Randomized host traffic
        rnd_datai = 1'b1;
        for (int it = 0; it < 400; it++) begin
            r = int'($urandom_range(0, 9));
            a = {(AW-BC)'($urandom_range(0, 3)), BC'($urandom)};
            if (r < 5)
                do_op(1'b1, 1'b0, a, 8'($urandom), int'($urandom_range(L + 4, L + 10)),
                      int'($urandom_range(0, 6)));
            else if (r < 6)
                do_op(1'b1, 1'b0, a, 8'($urandom), int'($urandom_range(1, 3)),
                      int'($urandom_range(0, 6)));
            else if (r < 9)
                do_op(1'b0, 1'b1, a, 8'($urandom), int'($urandom_range(1, 6)),
                      int'($urandom_range(0, 6)));
            else
                do_op(1'b1, 1'b1, a, 8'($urandom), int'($urandom_range(6, 10)),
                      int'($urandom_range(0, 6)));
        end
        wait_idle();
        repeat (2) @(negedge usb_clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
